// File: rtl/mux_b_if.sv
// mux_b operand bus: select inputs, combinational
// and registered operand outputs.
interface mux_b_if #(
  parameter int WIDTH = 11
);
  logic [WIDTH-1:0] EXT_in;
  logic [WIDTH-1:0] DATA_MEMORY_in;
  logic             sel_B;
  logic             load_B;
  logic [WIDTH-1:0] MB_out;
  logic [WIDTH-1:0] MB_reg_out;
  logic             MB_zero;
  logic             MB_src;

  modport master (
    output EXT_in,
    output DATA_MEMORY_in,
    output sel_B,
    output load_B,
    input  MB_out,
    input  MB_reg_out,
    input  MB_zero,
    input  MB_src
  );

  modport slave (
    input  EXT_in,
    input  DATA_MEMORY_in,
    input  sel_B,
    input  load_B,
    output MB_out,
    output MB_reg_out,
    output MB_zero,
    output MB_src
  );
endinterface

// File: rtl/mux_b.sv
// ALU B-operand selector: immediate vs memory word,
// with a load-enabled capture register for execute.
module mux_b #(
  parameter int               WIDTH       = 11,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic   clk,
  input logic   reset,
  mux_b_if.slave bus
);
  localparam logic RST_ZERO = (RESET_VALUE == '0);

  logic [WIDTH-1:0] mb_sel;

  // Select the operand; plain ?: keeps X-merge semantics.
  always_comb begin
    mb_sel = bus.sel_B ? bus.DATA_MEMORY_in
                       : bus.EXT_in;
  end

  assign bus.MB_out = mb_sel;

  // Capture operand and status when load_B is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.MB_reg_out <= RESET_VALUE;
      bus.MB_zero    <= RST_ZERO;
      bus.MB_src     <= 1'b0;
    end else if (bus.load_B) begin
      bus.MB_reg_out <= mb_sel;
      bus.MB_zero    <= (mb_sel == '0);
      bus.MB_src     <= bus.sel_B;
    end
  end
endmodule

// File: tb/tb_mux_b.sv
// Directed bench for mux_b: combinational select,
// capture, hold, async reset and reset release.
module tb_mux_b;
  localparam int W = 11;

  logic clk;
  logic reset;
  logic clk_en;
  int   n_chk;
  int   n_fail;

  mux_b_if #(.WIDTH(W)) bus ();

  mux_b #(
    .WIDTH(W),
    .RESET_VALUE('0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(
    input string      tag,
    input logic [W-1:0] r,
    input logic       z,
    input logic       s
  );
    chk({tag, "_reg"}, 32'(bus.MB_reg_out), 32'(r));
    chk({tag, "_zero"}, 32'(bus.MB_zero), 32'(z));
    chk({tag, "_src"}, 32'(bus.MB_src), 32'(s));
  endtask

  logic [5:0] seq;
  logic [W-1:0] exp_seq [6];
  logic [W-1:0] a;
  logic [W-1:0] b;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clk_en = 1'b0;
    reset  = 1'b1;
    bus.EXT_in         = '0;
    bus.DATA_MEMORY_in = '0;
    bus.sel_B          = 1'b0;
    bus.load_B         = 1'b0;
    #1;
    chk_reg("rst", 11'h000, 1'b1, 1'b0);
    reset = 1'b0;

    // combinational select, clock stopped
    bus.EXT_in         = 11'b00000000000;
    bus.DATA_MEMORY_in = 11'b00001001001;
    seq = 6'b100101;
    exp_seq = '{11'h049, 11'h000, 11'h049,
                11'h000, 11'h000, 11'h049};
    for (int i = 0; i < 6; i++) begin
      bus.sel_B = seq[i];
      #1;
      chk($sformatf("comb%0d", i),
          32'(bus.MB_out), 32'(exp_seq[i]));
    end

    // full-width pass-through
    bus.EXT_in         = 11'h7FF;
    bus.DATA_MEMORY_in = 11'h400;
    bus.sel_B = 1'b0;
    #1;
    chk("pass_ext", 32'(bus.MB_out), 32'h7FF);
    bus.sel_B = 1'b1;
    #1;
    chk("pass_dm", 32'(bus.MB_out), 32'h400);

    // walking ones in opposite directions
    for (int i = 0; i < W; i++) begin
      a = 11'd1 << i;
      b = 11'd1 << (W - 1 - i);
      bus.EXT_in         = a;
      bus.DATA_MEMORY_in = b;
      bus.sel_B = 1'b0;
      #1;
      chk($sformatf("walk_e%0d", i),
          32'(bus.MB_out), 32'(a));
      bus.sel_B = 1'b1;
      #1;
      chk($sformatf("walk_d%0d", i),
          32'(bus.MB_out), 32'(b));
    end

    // register capture after a reset pulse
    reset = 1'b1;
    #2;
    reset = 1'b0;
    bus.sel_B          = 1'b1;
    bus.DATA_MEMORY_in = 11'h049;
    bus.EXT_in         = 11'h123;
    bus.load_B         = 1'b1;
    clk_en = 1'b1;
    tick();
    chk_reg("cap1", 11'h049, 1'b0, 1'b1);
    bus.sel_B  = 1'b0;
    bus.EXT_in = 11'h000;
    tick();
    chk_reg("cap2", 11'h000, 1'b1, 1'b0);

    // hold with load_B low
    bus.load_B = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sel_B          = i[0];
      bus.EXT_in         = 11'h111 + 11'(i);
      bus.DATA_MEMORY_in = 11'h700 + 11'(i);
      tick();
      chk_reg($sformatf("hold%0d", i),
              11'h000, 1'b1, 1'b0);
      chk($sformatf("hold_out%0d", i),
          32'(bus.MB_out),
          i[0] ? 32'h700 + 32'(i)
               : 32'h111 + 32'(i));
    end

    // reload 0x049, then async reset mid-cycle
    bus.sel_B          = 1'b1;
    bus.DATA_MEMORY_in = 11'h049;
    bus.load_B         = 1'b1;
    tick();
    chk_reg("reload", 11'h049, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_reg("arst", 11'h000, 1'b1, 1'b0);
    chk("arst_out", 32'(bus.MB_out), 32'h049);
    tick();
    chk_reg("arst_hold", 11'h000, 1'b1, 1'b0);
    chk("arst_out2", 32'(bus.MB_out), 32'h049);

    // release with load_B high
    reset = 1'b0;
    #1;
    chk_reg("rel_pre", 11'h000, 1'b1, 1'b0);
    tick();
    chk_reg("rel_cap", 11'h049, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end
endmodule
